eth_rx_ring: RTL and testbench



---
 rtl/eth_rx_ring_pkg.sv | 19 +
 rtl/eth_rx_ring_if.sv | 27 ++
 rtl/eth_rx_ring_ram.sv | 29 ++
 rtl/eth_rx_ring.sv | 125 ++++++++++++
 tb/tb_eth_rx_ring.sv | 176 +++++++++++++++++
 5 files changed

// File: rtl/eth_rx_ring_pkg.sv
// eth_rx_ring_pkg: shared FSM state, descriptor layout and width helpers for the receive ring
package eth_rx_ring_pkg;
  typedef enum logic [1:0] {IDLE, RECV, DROP} state_e;
  localparam int FLAG_TRUNC = 2;
  localparam int FLAG_ERR = 1;
  localparam int FLAG_FCS = 0;
  typedef struct packed {
    logic [15:0] len;
    logic truncated;
    logic error;
    logic fcs_err;
  } desc_t;
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hffff) ? v : v + 16'd1;
  endfunction
endpackage

// File: rtl/eth_rx_ring_if.sv
// eth_rx_ring_if: host-side register window of the receive ring
interface eth_rx_ring_if import eth_rx_ring_pkg::*; #(
  parameter int NSLOT = 4,
  parameter int SLOT_BYTES = 2048,
  parameter int HOST_W = 32
) ();
  localparam int AW = idx_w(SLOT_BYTES * 8 / HOST_W);
  localparam int CW = idx_w(NSLOT) + 1;
  localparam int LW = idx_w(SLOT_BYTES) + 1;
  logic host_rd_en;
  logic [AW-1:0] host_addr;
  logic [HOST_W-1:0] host_rdata;
  logic host_release;
  logic [CW-1:0] rx_count_o;
  logic [LW-1:0] rx_len_o;
  logic [2:0] rx_flags_o;
  logic [15:0] drop_cnt_o;
  logic irq_o;
  modport master (
    output host_rd_en, host_addr, host_release,
    input host_rdata, rx_count_o, rx_len_o, rx_flags_o, drop_cnt_o, irq_o
  );
  modport slave (
    input host_rd_en, host_addr, host_release,
    output host_rdata, rx_count_o, rx_len_o, rx_flags_o, drop_cnt_o, irq_o
  );
endinterface

// File: rtl/eth_rx_ring_ram.sv
// eth_rx_ring_ram: byte-write / word-read frame store with registered read data
module eth_rx_ring_ram import eth_rx_ring_pkg::*; #(
  parameter int DEPTH = 8192,
  parameter int HOST_W = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic we,
  input  logic [idx_w(DEPTH)-1:0] waddr,
  input  logic [7:0] wdata,
  input  logic re,
  input  logic [idx_w(DEPTH*8/HOST_W)-1:0] raddr,
  output logic [HOST_W-1:0] rdata
);
  localparam int BPW = HOST_W / 8;
  localparam int BW = idx_w(BPW);
  localparam int WA = idx_w(DEPTH);
  localparam int WORDS = DEPTH / BPW;
  logic [BPW-1:0][7:0] mem [WORDS];
  logic [HOST_W-1:0] rdata_q, rdata_d;
  // little-endian lanes: low address bits pick the byte within a host word
  always_ff @(posedge clk)
    if (we) mem[waddr[WA-1:BW]][waddr[BW-1:0]] <= wdata;
  always_comb rdata_d = re ? mem[raddr] : rdata_q;
  always_ff @(posedge clk)
    if (rst) rdata_q <= '0;
    else rdata_q <= rdata_d;
  assign rdata = rdata_q;
endmodule

// File: rtl/eth_rx_ring.sv
// eth_rx_ring: NSLOT-deep receive frame ring with descriptors; ETH_RX_RING_FCS_DROP_EN drops FCS-bad frames
module eth_rx_ring import eth_rx_ring_pkg::*; #(
  parameter int NSLOT = 4,
  parameter int SLOT_BYTES = 2048,
  parameter int HOST_W = 32
) (
  input  logic clk_rmii,
  input  logic reset_i,
  input  logic rx_frame_i,
  input  logic [7:0] rx_data_i,
  input  logic rx_byte_received_i,
  input  logic rx_error_i,
  input  logic rx_fcs_err_i,
  eth_rx_ring_if.slave host
);
  localparam int PW = idx_w(NSLOT);
  localparam int OB = idx_w(SLOT_BYTES);
  localparam int LW = OB + 1;
  localparam logic [OB:0] SB = (OB+1)'(SLOT_BYTES);
  localparam logic [PW:0] NS = (PW+1)'(NSLOT);
  state_e state_q, state_d;
  logic frame_q;
  logic [OB:0] off_q, off_d;
  logic trunc_q, trunc_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PW:0] count_q, count_d;
  logic [15:0] drop_q, drop_d;
  desc_t desc_q [NSLOT];
  desc_t desc_d [NSLOT];
  desc_t head;
  logic rise, fall, we, commit, release_ok, fcs_flag;
  logic [2:0] flags;
  always_comb begin
    rise = rx_frame_i & ~frame_q;
    fall = ~rx_frame_i & frame_q;
    state_d = state_q;
    off_d = off_q;
    trunc_d = trunc_q;
    wr_ptr_d = wr_ptr_q;
    drop_d = drop_q;
    desc_d = desc_q;
    we = 1'b0;
    commit = 1'b0;
    fcs_flag = rx_fcs_err_i;
    release_ok = host.host_release & (count_q != '0);
    case (state_q)
      IDLE: if (rise) begin
        state_d = (count_q < NS) ? RECV : DROP;
        off_d = '0;
        trunc_d = 1'b0;
        drop_d = (count_q < NS) ? drop_q : sat_inc16(drop_q);
      end
      RECV: begin
        if (rx_byte_received_i) begin
          we = off_q < SB;
          off_d = we ? off_q + (OB+1)'(1) : off_q;
          trunc_d = trunc_q | ~we;
        end
        // empty frames vanish silently; otherwise commit (or drop on FCS when enabled)
        if (fall) begin
          state_d = IDLE;
`ifdef ETH_RX_RING_FCS_DROP_EN
          fcs_flag = 1'b0;
          drop_d = (off_d != '0 && rx_fcs_err_i) ? sat_inc16(drop_q) : drop_q;
          commit = (off_d != '0) && !rx_fcs_err_i;
`else
          commit = off_d != '0;
`endif
        end
      end
      DROP: state_d = fall ? IDLE : DROP;
      default: state_d = IDLE;
    endcase
    if (commit) begin
      desc_d[wr_ptr_q] = '{len: 16'(off_d), truncated: trunc_d, error: rx_error_i, fcs_err: fcs_flag};
      wr_ptr_d = wr_ptr_q + PW'(1);
    end
    rd_ptr_d = release_ok ? rd_ptr_q + PW'(1) : rd_ptr_q;
    count_d = (commit == release_ok) ? count_q : commit ? count_q + (PW+1)'(1) : count_q - (PW+1)'(1);
  end
  always_ff @(posedge clk_rmii)
    if (reset_i) begin
      state_q <= IDLE;
      frame_q <= 1'b1;
      off_q <= '0;
      trunc_q <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q <= '0;
      drop_q <= '0;
      desc_q <= '{default: '0};
    end else begin
      state_q <= state_d;
      frame_q <= rx_frame_i;
      off_q <= off_d;
      trunc_q <= trunc_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q <= count_d;
      drop_q <= drop_d;
      desc_q <= desc_d;
    end
  always_comb begin
    head = (count_q != '0) ? desc_q[rd_ptr_q] : '0;
    flags = '0;
    flags[FLAG_TRUNC] = head.truncated;
    flags[FLAG_ERR] = head.error;
    flags[FLAG_FCS] = head.fcs_err;
  end
  assign host.rx_count_o = count_q;
  assign host.irq_o = count_q != '0;
  assign host.rx_len_o = LW'(head.len);
  assign host.rx_flags_o = flags;
  assign host.drop_cnt_o = drop_q;
  eth_rx_ring_ram #(.DEPTH(NSLOT * SLOT_BYTES), .HOST_W(HOST_W)) u_ram (
    .clk(clk_rmii),
    .rst(reset_i),
    .we(we),
    .waddr({wr_ptr_q, off_q[OB-1:0]}),
    .wdata(rx_data_i),
    .re(host.host_rd_en),
    .raddr({rd_ptr_q, host.host_addr}),
    .rdata(host.host_rdata)
  );
endmodule

// File: tb/tb_eth_rx_ring.sv
// tb_eth_rx_ring: directed self-checking bench for the receive ring
module tb_eth_rx_ring;
  logic clk = 1'b0;
  logic reset_i = 1'b1;
  logic rx_frame_i = 1'b0;
  logic [7:0] rx_data_i = '0;
  logic rx_byte_received_i = 1'b0;
  logic rx_error_i = 1'b0;
  logic rx_fcs_err_i = 1'b0;
  int checks = 0;
  int errors = 0;
  logic [31:0] rd;
  eth_rx_ring_if #(.NSLOT(4), .SLOT_BYTES(2048), .HOST_W(32)) hif ();
  eth_rx_ring #(.NSLOT(4), .SLOT_BYTES(2048), .HOST_W(32)) dut (
    .clk_rmii(clk),
    .reset_i(reset_i),
    .rx_frame_i(rx_frame_i),
    .rx_data_i(rx_data_i),
    .rx_byte_received_i(rx_byte_received_i),
    .rx_error_i(rx_error_i),
    .rx_fcs_err_i(rx_fcs_err_i),
    .host(hif)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic send(input int len, input logic [7:0] start, input logic err, input logic fcs, input logic rel);
    @(negedge clk);
    rx_frame_i = 1'b1;
    for (int k = 0; k < len; k++) begin
      @(negedge clk);
      rx_byte_received_i = 1'b1;
      rx_data_i = start + 8'(k);
    end
    @(negedge clk);
    rx_byte_received_i = 1'b0;
    rx_frame_i = 1'b0;
    rx_error_i = err;
    rx_fcs_err_i = fcs;
    hif.host_release = rel;
    @(negedge clk);
    rx_error_i = 1'b0;
    rx_fcs_err_i = 1'b0;
    hif.host_release = 1'b0;
  endtask
  task automatic release_head();
    @(negedge clk);
    hif.host_release = 1'b1;
    @(negedge clk);
    hif.host_release = 1'b0;
  endtask
  task automatic read_word(input int a, output logic [31:0] d);
    @(negedge clk);
    hif.host_rd_en = 1'b1;
    hif.host_addr = 9'(a);
    @(negedge clk);
    hif.host_rd_en = 1'b0;
    d = hif.host_rdata;
  endtask
  task automatic do_reset();
    @(negedge clk);
    reset_i = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset_i = 1'b0;
  endtask
  initial begin
    hif.host_rd_en = 1'b0;
    hif.host_addr = '0;
    hif.host_release = 1'b0;
    do_reset();
    chk("rst_count", 32'(hif.rx_count_o), 0);
    chk("rst_len", 32'(hif.rx_len_o), 0);
    chk("rst_flags", 32'(hif.rx_flags_o), 0);
    chk("rst_drop", 32'(hif.drop_cnt_o), 0);
    chk("rst_irq", 32'(hif.irq_o), 0);
    chk("rst_rdata", hif.host_rdata, 0);
    send(60, 8'h00, 1'b0, 1'b0, 1'b0);
    chk("f60_count", 32'(hif.rx_count_o), 1);
    chk("f60_len", 32'(hif.rx_len_o), 60);
    chk("f60_flags", 32'(hif.rx_flags_o), 0);
    chk("f60_irq", 32'(hif.irq_o), 1);
    read_word(0, rd);
    chk("f60_w0", rd, 32'h03020100);
    read_word(14, rd);
    chk("f60_w14", rd, 32'h3b3a3938);
    repeat (3) @(negedge clk);
    chk("rdata_hold", hif.host_rdata, 32'h3b3a3938);
    release_head();
    chk("rel_count", 32'(hif.rx_count_o), 0);
    chk("rel_len", 32'(hif.rx_len_o), 0);
    chk("rel_irq", 32'(hif.irq_o), 0);
    release_head();
    chk("rel_empty_count", 32'(hif.rx_count_o), 0);
    do_reset();
    for (int i = 0; i < 5; i++) send(10 * (i + 1), 8'h40 + 8'(16 * i), 1'b0, 1'b0, 1'b0);
    chk("full_count", 32'(hif.rx_count_o), 4);
    chk("full_drop", 32'(hif.drop_cnt_o), 1);
    chk("full_len", 32'(hif.rx_len_o), 10);
    read_word(0, rd);
    chk("full_w0", rd, 32'h43424140);
    release_head();
    chk("full_rel_count", 32'(hif.rx_count_o), 3);
    chk("full_rel_len", 32'(hif.rx_len_o), 20);
    send(8, 8'ha0, 1'b0, 1'b0, 1'b0);
    chk("wrap_count", 32'(hif.rx_count_o), 4);
    release_head();
    chk("wrap_len30", 32'(hif.rx_len_o), 30);
    release_head();
    chk("wrap_len40", 32'(hif.rx_len_o), 40);
    release_head();
    chk("wrap_len8", 32'(hif.rx_len_o), 8);
    chk("wrap_count1", 32'(hif.rx_count_o), 1);
    read_word(0, rd);
    chk("wrap_w0", rd, 32'ha3a2a1a0);
    read_word(1, rd);
    chk("wrap_w1", rd, 32'ha7a6a5a4);
    release_head();
    send(2100, 8'h00, 1'b0, 1'b0, 1'b0);
    chk("trunc_len", 32'(hif.rx_len_o), 2048);
    chk("trunc_flags", 32'(hif.rx_flags_o), 3'b100);
    read_word(511, rd);
    chk("trunc_last", rd, 32'hfffefdfc);
    release_head();
    send(5, 8'h11, 1'b0, 1'b0, 1'b0);
    send(7, 8'h22, 1'b0, 1'b0, 1'b0);
    chk("pair_count", 32'(hif.rx_count_o), 2);
    send(9, 8'h33, 1'b0, 1'b0, 1'b1);
    chk("same_count", 32'(hif.rx_count_o), 2);
    chk("same_len", 32'(hif.rx_len_o), 7);
    release_head();
    chk("same_next_len", 32'(hif.rx_len_o), 9);
    release_head();
    chk("same_empty", 32'(hif.rx_count_o), 0);
    send(12, 8'h55, 1'b0, 1'b1, 1'b0);
`ifdef ETH_RX_RING_FCS_DROP_EN
    chk("fcs_count", 32'(hif.rx_count_o), 0);
    chk("fcs_drop", 32'(hif.drop_cnt_o), 2);
`else
    chk("fcs_count", 32'(hif.rx_count_o), 1);
    chk("fcs_flags", 32'(hif.rx_flags_o), 3'b001);
    chk("fcs_len", 32'(hif.rx_len_o), 12);
    release_head();
`endif
    send(4, 8'h66, 1'b1, 1'b0, 1'b0);
    chk("err_flags", 32'(hif.rx_flags_o), 3'b010);
    release_head();
    @(negedge clk);
    rx_frame_i = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      rx_byte_received_i = 1'b1;
      rx_data_i = 8'(k);
      reset_i = (k == 10);
    end
    @(negedge clk);
    reset_i = 1'b0;
    rx_byte_received_i = 1'b0;
    rx_frame_i = 1'b0;
    @(negedge clk);
    chk("midrst_count", 32'(hif.rx_count_o), 0);
    chk("midrst_drop", 32'(hif.drop_cnt_o), 0);
    send(16, 8'hc0, 1'b0, 1'b0, 1'b0);
    chk("midrst_next_count", 32'(hif.rx_count_o), 1);
    chk("midrst_next_len", 32'(hif.rx_len_o), 16);
    read_word(3, rd);
    chk("midrst_next_w3", rd, 32'hcfcecdcc);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
